fma16_normalize: RTL and testbench

- Multicycle normalizer in the fma16 datapath, between the aligned-add stage and the rounding stage.
- Takes the raw 44-bit unsigned sum magnitude, pre-normalization exponent, sign and alignment sticky.
- Shifts the sum one bit per cycle until the leading one sits at bit LEAD_POS.
- Emits the normalized fraction, packed truncated result, exponent-with-overflow-flag and sticky in the form the rounding stage consumes.

---
 rtl/fma16_normalize.sv | 178 +++++++++++++++++
 tb/tb_fma16_normalize.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fma16_normalize.sv
// fma16_normalize
// Multicycle normalizer sitting between the aligned-add stage and the
// rounding stage of the fma16 datapath. It accepts one raw sum magnitude
// and shifts it one bit per cycle until the leading one lands on LEAD_POS.
// It then presents the result in the form the rounder consumes.
//
// Ports:
//   clk, reset_n             clock (rising edge), async active-low reset
//   flush                    synchronous abort to IDLE, beats all handshakes
//   in_valid / in_ready      input handshake; in_ready is high only in IDLE
//   sum_in, exp_in, sign_in, sticky_in
//                            raw sum magnitude, signed pre-normalization
//                            exponent, sign, and alignment sticky
//   out_valid / out_ready    output handshake; outputs are held while stalled
//   normalized_fraction_sum  shifted sum with the leading one at LEAD_POS
//   exponent_sum1            {ovf, exp[4:0]}; 6'b100000 on overflow
//   result_sum               truncated {sign, exp[4:0], fraction[9:0]}
//   sticky_bit               sticky_in OR all bits lost to right shifts
//   zero                     input sum was zero
//   underflow                left shifting stopped at the exponent floor of 1
module fma16_normalize #(
    parameter int WIDTH    = 44,
    parameter int LEAD_POS = 32,
    parameter int EXP_W    = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        sum_in,
    input  logic signed [EXP_W-1:0] exp_in,
    input  logic                    sign_in,
    input  logic                    sticky_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        normalized_fraction_sum,
    output logic [5:0]              exponent_sum1,
    output logic [15:0]             result_sum,
    output logic                    sticky_bit,
    output logic                    zero,
    output logic                    underflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic signed [EXP_W-1:0] EXP_MAX = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic signed [EXP_W-1:0] EXP_OVF = EXP_W'(31);

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          sum_q, sum_d;
    logic signed [EXP_W-1:0]   exp_q, exp_d;
    logic                      sign_q, sign_d;
    logic                      sticky_q, sticky_d;
    logic                      out_valid_q, out_valid_d;
    logic                      zero_q, zero_d;
    logic                      underflow_q, underflow_d;
    logic [5:0]                exps_q, exps_d;
    logic [15:0]               result_q, result_d;
    logic                      above_lead;
    logic                      ovf;

    // Any set bit above the lead position forces a right shift first.
    assign above_lead = |sum_q[WIDTH-1:LEAD_POS+1];
    assign ovf        = (exp_q >= EXP_OVF);

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        underflow_d = underflow_q;
        exps_d      = exps_q;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sum_d       = sum_in;
                    exp_d       = exp_in;
                    sign_d      = sign_in;
                    sticky_d    = sticky_in;
                    zero_d      = 1'b0;
                    underflow_d = 1'b0;
                    if (sum_in == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        zero_d      = 1'b1;
                        result_d    = {sign_in, 15'b0};
                        exps_d      = 6'd0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (above_lead) begin
                    sum_d    = sum_q >> 1;
                    // Saturate rather than wrap into a negative exponent.
                    exp_d    = (exp_q == EXP_MAX) ? exp_q : exp_q + EXP_W'(1);
                    sticky_d = sticky_q | sum_q[0];
                end else if (!sum_q[LEAD_POS] && exp_q > 1) begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - EXP_W'(1);
                end else begin
                    // Either normalized, or stuck at the exponent floor.
                    // Exponent is unchanged here, so pack from exp_q.
                    underflow_d = ~sum_q[LEAD_POS];
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    exps_d      = ovf ? 6'b100000 : {1'b0, exp_q[4:0]};
                    result_d    = {sign_q, (ovf ? 5'b11111 : exp_q[4:0]),
                                   sum_q[LEAD_POS-1:LEAD_POS-10]};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything, including a same-cycle accept.
        if (flush) begin
            state_d     = IDLE;
            sum_d       = sum_q;
            exp_d       = exp_q;
            sign_d      = sign_q;
            out_valid_d = 1'b0;
            zero_d      = 1'b0;
            underflow_d = 1'b0;
            sticky_d    = 1'b0;
            exps_d      = exps_q;
            result_d    = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            underflow_q <= 1'b0;
            exps_q      <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            underflow_q <= underflow_d;
            exps_q      <= exps_d;
            result_q    <= result_d;
        end
    end

    assign in_ready                = (state_q == IDLE);
    assign out_valid               = out_valid_q;
    assign normalized_fraction_sum = sum_q;
    assign exponent_sum1           = exps_q;
    assign result_sum              = result_q;
    assign sticky_bit              = sticky_q;
    assign zero                    = zero_q;
    assign underflow               = underflow_q;

endmodule

// File: tb/tb_fma16_normalize.sv
module tb_fma16_normalize;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [43:0]       sum_in;
    logic signed [6:0] exp_in;
    logic              sign_in;
    logic              sticky_in;
    logic              out_valid;
    logic              out_ready;
    logic [43:0]       nfs;
    logic [5:0]        exps;
    logic [15:0]       res;
    logic              sticky_bit;
    logic              zero;
    logic              underflow;

    int errors = 0;
    int checks = 0;

    fma16_normalize dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .flush                  (flush),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .sum_in                 (sum_in),
        .exp_in                 (exp_in),
        .sign_in                (sign_in),
        .sticky_in              (sticky_in),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .normalized_fraction_sum(nfs),
        .exponent_sum1          (exps),
        .result_sum             (res),
        .sticky_bit             (sticky_bit),
        .zero                   (zero),
        .underflow              (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at E0, then count edges until out_valid; returns edge index.
    task automatic run_op(input logic [43:0] s, input logic signed [6:0] e,
                          input logic sg, input logic st, output int lat);
        sum_in = s; exp_in = e; sign_in = sg; sticky_in = st; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
            if (k == 1) check("in_ready_busy", {63'b0, in_ready}, 64'd0);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_valid", {63'b0, out_valid}, 64'd0);
        check("drain_ready", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] held;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sum_in = '0; exp_in = '0; sign_in = 1'b0; sticky_in = 1'b0;
        #12;
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", {48'b0, res}, 64'd0);
        check("rst_exps", {58'b0, exps}, 64'd0);
        check("rst_flags", {61'b0, zero, underflow, sticky_bit}, 64'd0);
        reset_n = 1'b1;
        tick();

        // Already normalized
        run_op(44'h001_0000_0000, 7'sd15, 1'b0, 1'b0, lat);
        check("t1_lat", 64'(lat), 64'd1);
        check("t1_result", {48'b0, res}, 64'h3C00);
        check("t1_exps", {58'b0, exps}, 64'd15);
        check("t1_sticky", {63'b0, sticky_bit}, 64'd0);
        check("t1_nfs", {20'b0, nfs}, 64'h001_0000_0000);
        drain();
        check("t1_retain", {48'b0, res}, 64'h3C00);

        // Two right shifts, bit 0 lost to sticky
        run_op(44'h004_0000_0001, 7'sd15, 1'b0, 1'b0, lat);
        check("t2_lat", 64'(lat), 64'd3);
        check("t2_exps", {58'b0, exps}, 64'd17);
        check("t2_result", {48'b0, res}, 64'h4400);
        check("t2_sticky", {63'b0, sticky_bit}, 64'd1);
        check("t2_nfs", {20'b0, nfs}, 64'h001_0000_0000);
        drain();

        // One left shift, negative sign
        run_op(44'h000_8000_0000, 7'sd15, 1'b1, 1'b0, lat);
        check("t3_lat", 64'(lat), 64'd2);
        check("t3_result", {48'b0, res}, 64'hB800);
        check("t3_exps", {58'b0, exps}, 64'd14);
        drain();

        // Overflow after three right shifts (exp 32)
        run_op(44'h008_0000_0000, 7'sd29, 1'b0, 1'b0, lat);
        check("t4_lat", 64'(lat), 64'd4);
        check("t4_exps", {58'b0, exps}, 64'h20);
        check("t4_result", {48'b0, res}, 64'h7C00);
        drain();

        // Zero input
        run_op(44'h0, 7'sd10, 1'b1, 1'b0, lat);
        check("t4z_lat", 64'(lat), 64'd1);
        check("t4z_zero", {63'b0, zero}, 64'd1);
        check("t4z_result", {48'b0, res}, 64'h8000);
        check("t4z_exps", {58'b0, exps}, 64'd0);
        drain();

        // Two left shifts then underflow at exponent 1
        run_op(44'h000_0010_0000, 7'sd3, 1'b0, 1'b0, lat);
        check("t5_lat", 64'(lat), 64'd3);
        check("t5_uf", {63'b0, underflow}, 64'd1);
        check("t5_exps", {58'b0, exps}, 64'd1);
        check("t5_result", {48'b0, res}, 64'h0401);
        check("t5_zero", {63'b0, zero}, 64'd0);

        // Stall in DONE for 5 cycles
        held = res;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", {63'b0, out_valid}, 64'd1);
            check("hold_ready", {63'b0, in_ready}, 64'd0);
            check("hold_result", {48'b0, res}, {48'b0, held});
        end
        drain();

        // Reset during a long left-shift sequence
        sum_in = 44'h1; exp_in = 7'sd40; sign_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", {63'b0, out_valid}, 64'd0);
        check("rst_mid_ready", {63'b0, in_ready}, 64'd1);
        #3 reset_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) lat = 1;
        end
        check("rst_no_output", 64'(lat), 64'd0);

        // Flush during SHIFT, with a competing in_valid
        sum_in = 44'h1; exp_in = 7'sd40; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_flush_busy", {63'b0, in_ready}, 64'd0);
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_ready", {63'b0, in_ready}, 64'd1);
        check("flush_valid", {63'b0, out_valid}, 64'd0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) lat = 1;
        end
        check("flush_no_output", 64'(lat), 64'd0);

        // Block still usable after flush
        run_op(44'h001_0000_0000, 7'sd15, 1'b0, 1'b0, lat);
        check("post_flush_lat", 64'(lat), 64'd1);
        check("post_flush_result", {48'b0, res}, 64'h3C00);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
